// File: rtl/plot_pkg.sv
// Shared types and screen geometry for the pixel-plot scheduler.
package plot_pkg;
    localparam int SCREEN_XW = 8;
    localparam int SCREEN_YW = 7;
    localparam int COLOUR_W  = 3;

    typedef enum logic [1:0] {SRC_CLR, SRC_PLY, SRC_CPU, SRC_NONE} src_t;
    typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/plot_rr_arb.sv
// Two-requester round-robin picker; req[0]=player, req[1]=cpu, rr_ptr 0=player.
module plot_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = rr_ptr_q ? 2'b10 : 2'b01;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) rr_ptr_d = ~rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= 1'b0;
        else     rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/plot_scheduler.sv
// Arbitrates clear/player/cpu pixel bursts onto one registered adapter write port.
// Optional PLOT_STATS_EN adds saturating per-source accepted-beat counters.
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ended,
    input  logic                 clr_valid,
    input  logic                 clr_last,
    input  logic [SCREEN_XW-1:0] clr_x,
    input  logic [SCREEN_YW-1:0] clr_y,
    input  logic [COLOUR_W-1:0]  clr_col,
    output logic                 clr_ready,
    input  logic                 ply_valid,
    input  logic                 ply_last,
    input  logic [SCREEN_XW-1:0] ply_x,
    input  logic [SCREEN_YW-1:0] ply_y,
    input  logic [COLOUR_W-1:0]  ply_col,
    output logic                 ply_ready,
    input  logic                 cpu_valid,
    input  logic                 cpu_last,
    input  logic [SCREEN_XW-1:0] cpu_x,
    input  logic [SCREEN_YW-1:0] cpu_y,
    input  logic [COLOUR_W-1:0]  cpu_col,
    output logic                 cpu_ready,
    output logic [SCREEN_XW-1:0] x,
    output logic [SCREEN_YW-1:0] y,
    output logic [COLOUR_W-1:0]  colour,
    output logic                 plot,
    output logic                 burst_err,
    output state_t               dbg_state
`ifdef PLOT_STATS_EN
    ,
    output logic [CNT_W-1:0]     clr_pix,
    output logic [CNT_W-1:0]     ply_pix,
    output logic [CNT_W-1:0]     cpu_pix
`endif
);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    state_t              state_q, state_d;
    src_t                owner_q, owner_d, winner, sel;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [1:0]          gnt;
    logic                sel_valid, sel_last, acc, wd_hit, burst_end;
    logic [SCREEN_XW-1:0] sel_x, x_q;
    logic [SCREEN_YW-1:0] sel_y, y_q;
    logic [COLOUR_W-1:0]  sel_col, colour_q;
    logic                plot_q, burst_err_q;

    // Sprites compete only for new grants; ended masks them here, never mid-burst.
    plot_rr_arb u_arb (
        .clk     (clk),
        .rst     (resetn),
        .req     ({cpu_valid & ~ended, ply_valid & ~ended}),
        .advance (burst_end && (sel == SRC_PLY || sel == SRC_CPU)),
        .gnt     (gnt)
    );

    always_comb begin
        winner = SRC_NONE;
        if (clr_valid)   winner = SRC_CLR;
        else if (gnt[0]) winner = SRC_PLY;
        else if (gnt[1]) winner = SRC_CPU;
        sel = (state_q == IDLE) ? winner : owner_q;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_col   = '0;
        case (sel)
            SRC_CLR: begin sel_valid = clr_valid; sel_last = clr_last; sel_x = clr_x; sel_y = clr_y; sel_col = clr_col; end
            SRC_PLY: begin sel_valid = ply_valid; sel_last = ply_last; sel_x = ply_x; sel_y = ply_y; sel_col = ply_col; end
            SRC_CPU: begin sel_valid = cpu_valid; sel_last = cpu_last; sel_x = cpu_x; sel_y = cpu_y; sel_col = cpu_col; end
            default: ;
        endcase
    end

    // Handshake: a beat moves when valid & ready; ready is a function of state and valids only.
    assign acc       = sel_valid;
    assign wd_hit    = acc && !sel_last && (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    assign burst_end = acc && (sel_last || wd_hit);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= IDLE;
            owner_q    <= SRC_NONE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: if (acc && !burst_end) begin
                state_d    = BURST;
                owner_d    = sel;
                beat_cnt_d = BEAT_W'(1);
            end
            BURST: if (burst_end) begin
                state_d    = IDLE;
                owner_d    = SRC_NONE;
                beat_cnt_d = '0;
            end else if (acc) begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        clr_ready = (sel == SRC_CLR);
        ply_ready = (sel == SRC_PLY);
        cpu_ready = (sel == SRC_CPU);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            plot_q      <= acc;
            burst_err_q <= burst_err_q | wd_hit;
            if (acc) begin
                x_q      <= sel_x;
                y_q      <= sel_y;
                colour_q <= sel_col;
            end
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign burst_err = burst_err_q;

`ifdef PLOT_STATS_EN
    logic [CNT_W-1:0] clr_pix_q, ply_pix_q, cpu_pix_q;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            clr_pix_q <= '0;
            ply_pix_q <= '0;
            cpu_pix_q <= '0;
        end else if (acc) begin
            if (sel == SRC_CLR && clr_pix_q != '1) clr_pix_q <= clr_pix_q + CNT_W'(1);
            if (sel == SRC_PLY && ply_pix_q != '1) ply_pix_q <= ply_pix_q + CNT_W'(1);
            if (sel == SRC_CPU && cpu_pix_q != '1) cpu_pix_q <= cpu_pix_q + CNT_W'(1);
        end
    end

    assign clr_pix = clr_pix_q;
    assign ply_pix = ply_pix_q;
    assign cpu_pix = cpu_pix_q;
`endif
endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler (MAX_BURST=4); covers PLOT_STATS_EN when defined.
module tb_plot_scheduler;
    import plot_pkg::*;

    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       ended = 1'b0;
    logic       clr_valid = 0, clr_last = 0, clr_ready;
    logic [7:0] clr_x = 0;
    logic [6:0] clr_y = 0;
    logic [2:0] clr_col = 0;
    logic       ply_valid = 0, ply_last = 0, ply_ready;
    logic [7:0] ply_x = 0;
    logic [6:0] ply_y = 0;
    logic [2:0] ply_col = 0;
    logic       cpu_valid = 0, cpu_last = 0, cpu_ready;
    logic [7:0] cpu_x = 0;
    logic [6:0] cpu_y = 0;
    logic [2:0] cpu_col = 0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, burst_err;
    state_t     dbg_state;
`ifdef PLOT_STATS_EN
    logic [CNT_W-1:0] clr_pix, ply_pix, cpu_pix;
`endif

    int n_checks = 0;
    int n_errors = 0;

    plot_scheduler #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .ended(ended),
        .clr_valid(clr_valid), .clr_last(clr_last), .clr_x(clr_x), .clr_y(clr_y), .clr_col(clr_col), .clr_ready(clr_ready),
        .ply_valid(ply_valid), .ply_last(ply_last), .ply_x(ply_x), .ply_y(ply_y), .ply_col(ply_col), .ply_ready(ply_ready),
        .cpu_valid(cpu_valid), .cpu_last(cpu_last), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_col(cpu_col), .cpu_ready(cpu_ready),
        .x(x), .y(y), .colour(colour), .plot(plot), .burst_err(burst_err), .dbg_state(dbg_state)
`ifdef PLOT_STATS_EN
        , .clr_pix(clr_pix), .ply_pix(ply_pix), .cpu_pix(cpu_pix)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_clr(input logic v, input logic l, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        clr_valid = v; clr_last = l; clr_x = xx; clr_y = yy; clr_col = cc;
    endtask

    task automatic set_ply(input logic v, input logic l, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        ply_valid = v; ply_last = l; ply_x = xx; ply_y = yy; ply_col = cc;
    endtask

    task automatic set_cpu(input logic v, input logic l, input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        cpu_valid = v; cpu_last = l; cpu_x = xx; cpu_y = yy; cpu_col = cc;
    endtask

    task automatic idle_all();
        set_clr(0, 0, 0, 0, 0);
        set_ply(0, 0, 0, 0, 0);
        set_cpu(0, 0, 0, 0, 0);
    endtask

    // Rows: ply_x, ply_last, cpu_x, cpu_last, exp ply_ready, exp cpu_ready, exp x after edge.
    int rr_tab [9][7] = '{
        '{8'h10, 0, 8'h20, 0, 1, 0, 8'h10},
        '{8'h11, 0, 8'h20, 0, 1, 0, 8'h11},
        '{8'h12, 1, 8'h20, 0, 1, 0, 8'h12},
        '{8'h13, 0, 8'h20, 0, 0, 1, 8'h20},
        '{8'h13, 0, 8'h21, 0, 0, 1, 8'h21},
        '{8'h13, 0, 8'h22, 1, 0, 1, 8'h22},
        '{8'h13, 0, 8'h23, 0, 1, 0, 8'h13},
        '{8'h14, 0, 8'h23, 0, 1, 0, 8'h14},
        '{8'h15, 1, 8'h23, 0, 1, 0, 8'h15}
    };

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_plot", 32'(plot), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_colour", 32'(colour), 0);
        chk("rst_burst_err", 32'(burst_err), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        resetn = 1'b0;
        tick();
        chk("post_rst_plot", 32'(plot), 0);

        // Clear has priority, 1-cycle latency
        set_clr(1, 1, 8'd5, 7'd6, 3'b111);
        set_ply(1, 1, 8'd1, 7'd1, 3'd1);
        set_cpu(1, 1, 8'd2, 7'd2, 3'd2);
        #1;
        chk("t1_clr_rdy", 32'(clr_ready), 1);
        chk("t1_ply_rdy", 32'(ply_ready), 0);
        chk("t1_cpu_rdy", 32'(cpu_ready), 0);
        tick();
        chk("t1_plot", 32'(plot), 1);
        chk("t1_x", 32'(x), 5);
        chk("t1_y", 32'(y), 6);
        chk("t1_colour", 32'(colour), 7);
        set_clr(0, 0, 0, 0, 0);
        #1;
        chk("t1_ply_rdy_next", 32'(ply_ready), 1);
        chk("t1_cpu_rdy_next", 32'(cpu_ready), 0);
        idle_all();
        tick();
        chk("t1_plot_drop", 32'(plot), 0);
        chk("t1_x_hold", 32'(x), 5);

        // Round-robin between continuously requesting sprites
        for (int r = 0; r < 9; r++) begin
            set_ply(1, rr_tab[r][1] != 0, 8'(rr_tab[r][0]), 7'd10, 3'd1);
            set_cpu(1, rr_tab[r][3] != 0, 8'(rr_tab[r][2]), 7'd20, 3'd2);
            #1;
            chk($sformatf("t2_ply_rdy_%0d", r), 32'(ply_ready), 32'(rr_tab[r][4]));
            chk($sformatf("t2_cpu_rdy_%0d", r), 32'(cpu_ready), 32'(rr_tab[r][5]));
            tick();
            chk($sformatf("t2_plot_%0d", r), 32'(plot), 1);
            chk($sformatf("t2_x_%0d", r), 32'(x), 32'(rr_tab[r][6]));
        end
        idle_all();
        tick();

        // No preemption of a player burst by clear; owner bubble keeps ready high
        set_ply(1, 0, 8'h30, 7'd3, 3'd3);
        tick();
        chk("t3_x0", 32'(x), 8'h30);
        set_ply(1, 0, 8'h31, 7'd3, 3'd3);
        set_clr(1, 1, 8'h40, 7'd4, 3'd4);
        #1;
        chk("t3_clr_held", 32'(clr_ready), 0);
        tick();
        chk("t3_x1", 32'(x), 8'h31);
        set_ply(0, 0, 8'h99, 7'd3, 3'd3);
        #1;
        chk("t3_bubble_rdy", 32'(ply_ready), 1);
        tick();
        chk("t3_bubble_plot", 32'(plot), 0);
        chk("t3_bubble_x", 32'(x), 8'h31);
        set_ply(1, 0, 8'h32, 7'd3, 3'd3);
        tick();
        chk("t3_x2", 32'(x), 8'h32);
        set_ply(1, 1, 8'h33, 7'd3, 3'd3);
        #1;
        chk("t3_clr_held_last", 32'(clr_ready), 0);
        tick();
        chk("t3_x3", 32'(x), 8'h33);
        set_ply(0, 0, 0, 0, 0);
        #1;
        chk("t3_clr_rdy", 32'(clr_ready), 1);
        tick();
        chk("t3_clr_plot", 32'(plot), 1);
        chk("t3_clr_x", 32'(x), 8'h40);
        chk("t3_no_err", 32'(burst_err), 0);
        idle_all();
        tick();

        // Watchdog releases a cpu burst that never signals last
        for (int b = 0; b < 7; b++) begin
            set_cpu(1, b == 6, 8'(8'h50 + b), 7'd5, 3'd5);
            #1;
            chk($sformatf("t4_cpu_rdy_%0d", b), 32'(cpu_ready), 1);
            tick();
            chk($sformatf("t4_x_%0d", b), 32'(x), 32'(8'h50 + b));
            chk($sformatf("t4_err_%0d", b), 32'(burst_err), (b >= 3) ? 1 : 0);
            if (b == 3) chk("t4_state_released", 32'(dbg_state), 32'(IDLE));
            if (b == 4) chk("t4_state_new_burst", 32'(dbg_state), 32'(BURST));
        end
        idle_all();
        tick();
        chk("t4_err_sticky", 32'(burst_err), 1);

        // ended masks new sprite grants but not a running burst
        ended = 1'b1;
        set_ply(1, 0, 8'h70, 7'd7, 3'd7);
        #1;
        chk("t5_ply_masked", 32'(ply_ready), 0);
        tick();
        chk("t5_no_plot", 32'(plot), 0);
        ended = 1'b0;
        set_ply(0, 0, 0, 0, 0);
        set_cpu(1, 0, 8'h60, 7'd6, 3'd6);
        tick();
        chk("t5_cpu0", 32'(x), 8'h60);
        ended = 1'b1;
        set_ply(1, 0, 8'h70, 7'd7, 3'd7);
        set_cpu(1, 0, 8'h61, 7'd6, 3'd6);
        #1;
        chk("t5_cpu_cont", 32'(cpu_ready), 1);
        tick();
        chk("t5_cpu1", 32'(x), 8'h61);
        set_cpu(1, 1, 8'h62, 7'd6, 3'd6);
        tick();
        chk("t5_cpu2", 32'(x), 8'h62);
        set_cpu(1, 0, 8'h63, 7'd6, 3'd6);
        set_clr(1, 1, 8'h41, 7'd4, 3'd4);
        #1;
        chk("t5_clr_rdy", 32'(clr_ready), 1);
        chk("t5_cpu_masked", 32'(cpu_ready), 0);
        tick();
        chk("t5_clr_x", 32'(x), 8'h41);
        set_clr(0, 0, 0, 0, 0);
        #1;
        chk("t5_ply_rdy_ended", 32'(ply_ready), 0);
        chk("t5_cpu_rdy_ended", 32'(cpu_ready), 0);
        tick();
        chk("t5_idle_plot", 32'(plot), 0);
        idle_all();
        ended = 1'b0;
        tick();

        // Asynchronous reset mid-burst
        set_cpu(1, 0, 8'h64, 7'd9, 3'd3);
        tick();
        chk("t6_plot_before", 32'(plot), 1);
        chk("t6_state_burst", 32'(dbg_state), 32'(BURST));
        set_cpu(0, 0, 0, 0, 0);
        #2;
        resetn = 1'b1;
        #1;
        chk("t6_plot_async", 32'(plot), 0);
        chk("t6_x_async", 32'(x), 0);
        chk("t6_y_async", 32'(y), 0);
        chk("t6_colour_async", 32'(colour), 0);
        chk("t6_err_async", 32'(burst_err), 0);
        chk("t6_state_async", 32'(dbg_state), 32'(IDLE));
        tick();
        resetn = 1'b0;
`ifdef PLOT_STATS_EN
        chk("t6_clr_pix0", 32'(clr_pix), 0);
        chk("t6_ply_pix0", 32'(ply_pix), 0);
        chk("t6_cpu_pix0", 32'(cpu_pix), 0);
`endif
        for (int b = 0; b < 10; b++) begin
            set_clr(1, b == 9, 8'(8'h80 + b), 7'd1, 3'd1);
            tick();
            chk($sformatf("t6_clr_x_%0d", b), 32'(x), 32'(8'h80 + b));
        end
        idle_all();
        tick();
        chk("t6_clr_err", 32'(burst_err), 1);
        chk("t6_final_plot", 32'(plot), 0);
`ifdef PLOT_STATS_EN
        chk("t6_clr_pix10", 32'(clr_pix), 10);
        chk("t6_ply_pix_after", 32'(ply_pix), 0);
        chk("t6_cpu_pix_after", 32'(cpu_pix), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
